bus_grant_arbiter: RTL and testbench

//  Round-robin arbiter that shares one bus among 8 requesters.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/grant_decode.sv | 16 +
 rtl/bus_grant_arbiter.sv | 110 +++++++++++
 tb/tb_bus_grant_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared bus-side definitions: requester count, select width and the arbiter state type.
package cpu_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage : cpu_pkg

// File: rtl/grant_decode.sv
// 3-to-8 enable decoder: turns the registered select/enable pair into a one-hot grant.
module grant_decode
  import cpu_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N_REQ-1:0] gnt
);

  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = '0;
    if (en) gnt[sel] = 1'b1;
  end

endmodule : grant_decode

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter for 8 masters: holds each grant until DONE, a dropped request or timeout,
// then rotates priority past the last winner.
module bus_grant_arbiter
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             terr_q, terr_d;

  logic             found;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] idx;

  // Rotating find-first: scan ptr, ptr+1, ... with natural 3-bit wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr_q + SEL_W'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  logic rel_done, rel_drop, rel_tmo, release_now;

  assign rel_done    = done;
  assign rel_drop    = !req[sel_q];
  assign rel_tmo     = (timer_q == TMR_LAST);
  assign release_now = rel_done || rel_drop || rel_tmo;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    terr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          sel_d   = winner;
          timer_d = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = sel_q + SEL_W'(1);
          timer_d = '0;
          // Timeout is only an error when the master neither finished nor walked away.
          terr_d  = rel_tmo && !rel_done && !rel_drop;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      terr_q  <= terr_d;
    end
  end

  assign sel         = sel_q;
  assign en          = (state_q == BUSY);
  assign busy        = en;
  assign timeout_err = terr_q;

  grant_decode u_grant_decode (
    .sel (sel_q),
    .en  (en),
    .gnt (gnt)
  );

endmodule : bus_grant_arbiter

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter: an ownership/hold-count model checked every cycle,
// plus directed scenarios with hand-computed grant values.
module tb_bus_grant_arbiter;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;

  bus_grant_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .TMR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .sel         (sel),
    .en          (en),
    .gnt         (gnt),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: which master owns the bus (-1 = nobody), how many cycles it has held it,
  // the last master granted, and where the next search begins.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  int m_ptr   = 0;
  bit m_terr  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 0;
      m_ptr   = 0;
      m_terr  = 1'b0;
    end else begin
      m_terr = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            m_last  = m_owner;
            m_held  = 1;
          end
        end
      end else if (done || !req[m_owner] || m_held == TIMEOUT) begin
        m_terr  = !done && req[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  end

  always @(negedge clk) begin
    check("model_en",   {31'b0, en},          {31'b0, m_owner >= 0});
    check("model_busy", {31'b0, busy},        {31'b0, m_owner >= 0});
    check("model_sel",  {29'b0, sel},         m_last);
    check("model_gnt",  {24'b0, gnt},         (m_owner >= 0) ? (32'd1 << m_last) : 32'd0);
    check("model_terr", {31'b0, timeout_err}, {31'b0, m_terr});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fresh_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset with all requests pending, then an asynchronous mid-cycle reset.
    #1 rst_n = 1'b0;
    req = 8'hFF;
    cyc(); cyc();
    check("rst_sel",  {29'b0, sel}, 32'd0);
    check("rst_en",   {31'b0, en},  32'd0);
    check("rst_gnt",  {24'b0, gnt}, 32'h00);
    check("rst_terr", {31'b0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    cyc();
    check("first_gnt", {24'b0, gnt}, 32'h01);
    #1 rst_n = 1'b0;
    #1;
    check("async_gnt", {24'b0, gnt}, 32'h00);
    check("async_en",  {31'b0, en},  32'd0);
    cyc();
    req   = 8'h00;
    rst_n = 1'b1;

    // 2: single request, DONE release, search resumes at 3.
    cyc();
    req = 8'h04;
    cyc();
    check("t2_sel", {29'b0, sel}, 32'd2);
    check("t2_en",  {31'b0, en},  32'd1);
    check("t2_gnt", {24'b0, gnt}, 32'h04);
    done = 1'b1;
    req  = 8'h0C;
    cyc();
    done = 1'b0;
    check("t2_release", {24'b0, gnt}, 32'h00);
    cyc();
    check("t2_next", {24'b0, gnt}, 32'h08);
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 8'h00;
    cyc();

    // 3: fairness sweep with every master requesting.
    fresh_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cyc();
      check("t3_gnt", {24'b0, gnt}, 32'd1 << (k % 8));
      done = 1'b1;
      cyc();
      done = 1'b0;
      check("t3_gap", {31'b0, en}, 32'd0);
    end

    // 4: wrap from ptr=7 lands on master 0.
    fresh_reset();
    req = 8'h40;
    cyc();
    check("t4_gnt6", {24'b0, gnt}, 32'h40);
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 8'h03;
    cyc();
    check("t4_wrap", {24'b0, gnt}, 32'h01);
    done = 1'b1;
    cyc();
    done = 1'b0;
    req  = 8'h00;
    cyc();

    // 5: forced release after 16 cycles, then DONE coinciding with the last timer value.
    req = 8'h10;
    cyc();
    check("t5_gnt", {24'b0, gnt}, 32'h10);
    for (int k = 1; k < TIMEOUT; k++) begin
      cyc();
      check("t5_hold", {24'b0, gnt}, 32'h10);
    end
    cyc();
    check("t5_tmo_en",  {31'b0, en},          32'd0);
    check("t5_tmo_err", {31'b0, timeout_err}, 32'd1);
    cyc();
    check("t5_regrant", {24'b0, gnt}, 32'h10);
    check("t5_err_off", {31'b0, timeout_err}, 32'd0);
    for (int k = 1; k < TIMEOUT; k++) cyc();
    check("t5_last", {24'b0, gnt}, 32'h10);
    done = 1'b1;
    cyc();
    done = 1'b0;
    check("t5_done_en",  {31'b0, en},          32'd0);
    check("t5_done_err", {31'b0, timeout_err}, 32'd0);
    req = 8'h00;
    cyc();

    // 6: asynchronous reset while master 5 owns the bus; pointer returns to 0.
    req = 8'h20;
    cyc();
    check("t6_gnt5", {24'b0, gnt}, 32'h20);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_gnt", {24'b0, gnt}, 32'h00);
    check("t6_async_en",  {31'b0, en},  32'd0);
    cyc();
    rst_n = 1'b1;
    req   = 8'h21;
    cyc();
    check("t6_ptr0", {24'b0, gnt}, 32'h01);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_bus_grant_arbiter
